// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - arbiter sharing one single-port memory between fetch and data ports
//
// Serialises instruction-fetch (I) and load/store (D) accesses onto a single
// enable/ready memory port. One transaction at a time: IDLE -> ACCESS -> RESP.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D wins over I when both request in IDLE
//   defined   : contested grants go to the port that did not win last time
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   iReq/iAddr            fetch request (held until iReady) and address
//   iReady/iData          one-cycle completion pulse and fetched word (held)
//   dReq/dWrite/dAddr     data request, store flag, address
//   dWData/dWMask         store data and bit mask
//   dReady/dRData         one-cycle completion pulse and load data (0 for stores, held)
//   memEnable/memWrite    memory access in progress / write strobe
//   memAddr/memWData/memWMask  latched address, store data, store mask
//   memReady/memRData     memory completion and read data
//   busy                  high whenever the arbiter is not in IDLE
module unified_mem_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iReq,
    input  logic [AddrWidth-1:0] iAddr,
    output logic                 iReady,
    output logic [DataWidth-1:0] iData,
    input  logic                 dReq,
    input  logic                 dWrite,
    input  logic [AddrWidth-1:0] dAddr,
    input  logic [DataWidth-1:0] dWData,
    input  logic [DataWidth-1:0] dWMask,
    output logic                 dReady,
    output logic [DataWidth-1:0] dRData,
    output logic                 memEnable,
    output logic                 memWrite,
    output logic [AddrWidth-1:0] memAddr,
    output logic [DataWidth-1:0] memWData,
    output logic [DataWidth-1:0] memWMask,
    input  logic                 memReady,
    input  logic [DataWidth-1:0] memRData,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q;      // 0 = I, 1 = D
    logic                 write_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] wmask_q;
    logic [DataWidth-1:0] idata_q;
    logic [DataWidth-1:0] drdata_q;
    logic                 grant;        // winner in IDLE: 0 = I, 1 = D
    logic                 any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic                 last_owner_q;
`endif

    assign any_req = iReq | dReq;

    // Winner selection; only meaningful while in IDLE with any_req high.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (iReq && dReq) begin
            grant = ~last_owner_q;
        end else begin
            grant = dReq;
        end
`else
        grant = dReq;
`endif
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)  state_d = ACCESS;
            ACCESS:  if (memReady) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: all decoded from registers only, never from inputs
    always_comb begin
        busy      = 1'b0;
        memEnable = 1'b0;
        memWrite  = 1'b0;
        iReady    = 1'b0;
        dReady    = 1'b0;
        case (state_q)
            ACCESS: begin
                busy      = 1'b1;
                memEnable = 1'b1;
                memWrite  = write_q & owner_q;
            end
            RESP: begin
                busy   = 1'b1;
                iReady = ~owner_q;
                dReady = owner_q;
            end
            default: ;
        endcase
    end

    // Request latch and response data registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            idata_q  <= '0;
            drdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && any_req) begin
                owner_q <= grant;
                write_q <= grant & dWrite;
                addr_q  <= grant ? dAddr  : iAddr;
                wdata_q <= grant ? dWData : '0;
                wmask_q <= grant ? dWMask : '0;
`ifdef ARB_ROUND_ROBIN_EN
                last_owner_q <= grant;
`endif
            end
            if (state_q == ACCESS && memReady) begin
                if (owner_q) begin
                    drdata_q <= write_q ? '0 : memRData;
                end else begin
                    idata_q <= memRData;
                end
            end
        end
    end

    assign memAddr  = addr_q;
    assign memWData = wdata_q;
    assign memWMask = wmask_q;
    assign iData    = idata_q;
    assign dRData   = drdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iReq = 1'b0;
    logic [31:0] iAddr = '0;
    logic        iReady;
    logic [31:0] iData;
    logic        dReq = 1'b0;
    logic        dWrite = 1'b0;
    logic [31:0] dAddr = '0;
    logic [31:0] dWData = '0;
    logic [31:0] dWMask = '0;
    logic        dReady;
    logic [31:0] dRData;
    logic        memEnable;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memWMask;
    logic        memReady;
    logic [31:0] memRData;
    logic        busy;

    unified_mem_arbiter #(.AddrWidth(32), .DataWidth(32)) dut (
        .clock(clock), .reset(reset),
        .iReq(iReq), .iAddr(iAddr), .iReady(iReady), .iData(iData),
        .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWData(dWData), .dWMask(dWMask),
        .dReady(dReady), .dRData(dRData),
        .memEnable(memEnable), .memWrite(memWrite), .memAddr(memAddr),
        .memWData(memWData), .memWMask(memWMask),
        .memReady(memReady), .memRData(memRData), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          rcyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        int          scyc;
        int          w;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
    bit last_owner_m = 1'b0;
`endif

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A17C3E9;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] bus_read(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_word(a);
    endfunction

    // Wait-state memory model; also checks the memory-side request each cycle.
    bit   mem_active = 1'b0;
    acc_t cur;
    int   wcnt = 0;
    always @(negedge clock) begin
        memRData = $urandom;
        memReady = 1'b0;
        if (reset || !memEnable) begin
            mem_active = 1'b0;
        end else begin
            if (!mem_active) begin
                mem_active = 1'b1;
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_mem_access: got addr %0h, required no access (cycle %0d)", memAddr, cyc);
                    cur.addr = memAddr; cur.wr = memWrite; cur.wdata = memWData;
                    cur.wmask = memWMask; cur.scyc = cyc; cur.w = 0;
                end else begin
                    cur = acc_q.pop_front();
                end
                wcnt = cur.w;
                chk("mem_start_cycle", cyc, cur.scyc);
            end
            chk("mem_addr", memAddr, cur.addr);
            chk("mem_write", memWrite, cur.wr);
            chk("busy_access", busy, 1);
            if (cur.wr) begin
                chk("mem_wdata", memWData, cur.wdata);
                chk("mem_wmask", memWMask, cur.wmask);
            end
            if (wcnt == 0) begin
                memReady = 1'b1;
                memRData = bus_read(cur.addr);
                if (cur.wr) bus_mem[cur.addr] = (memRData & ~cur.wmask) | (cur.wdata & cur.wmask);
            end else begin
                wcnt--;
            end
        end
    end

    // Response monitor
    always @(negedge clock) begin
        if (!reset && (iReady || dReady)) begin
            if (iReady && dReady) begin
                total++;
                bad++;
                $display("FAIL dual_ready: got both iReady and dReady, required one (cycle %0d)", cyc);
            end
            if (rsp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got iReady=%0b dReady=%0b, required none (cycle %0d)", iReady, dReady, cyc);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("ready_port", dReady, e.port);
                chk("ready_cycle", cyc, e.rcyc);
                chk("ready_data", e.port ? dRData : iData, e.data);
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #3;
        reset = 1'b1;
        iReq = 1'b0;
        dReq = 1'b0;
        rsp_q.delete();
        acc_q.delete();
        last_i = '0;
        last_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_m = 1'b0;
`endif
        @(posedge clock); #2;
        reset = 1'b0;
    endtask

    // mode: 0 = fetch only, 1 = data only, 2 = both at once
    task automatic episode(input int mode, input logic [31:0] ia, input int wi,
                           input bit dw, input logic [31:0] da, input logic [31:0] dwd,
                           input logic [31:0] dwm, input int wd);
        int   seen;
        bit   order[$];
        bit   ip, dp;
        int   n;
        @(posedge clock); #1;
        seen = cyc;
        if (mode == 0) order.push_back(1'b0);
        else if (mode == 1) order.push_back(1'b1);
        else begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_owner_m) begin order.push_back(1'b0); order.push_back(1'b1); end
            else begin order.push_back(1'b1); order.push_back(1'b0); end
`else
            order.push_back(1'b1);
            order.push_back(1'b0);
`endif
        end
        foreach (order[k]) begin
            acc_t a;
            rsp_t r;
            bit   p;
            p = order[k];
            a.addr  = p ? da : ia;
            a.wr    = p & dw;
            a.wdata = dwd;
            a.wmask = dwm;
            a.w     = p ? wd : wi;
            a.scyc  = seen + 1;
            r.port  = p;
            r.rcyc  = seen + 2 + a.w;
            if (a.wr) begin
                ref_mem[da] = (ref_read(da) & ~dwm) | (dwd & dwm);
                r.data = '0;
            end else begin
                r.data = ref_read(a.addr);
            end
            if (p) last_d = r.data; else last_i = r.data;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_m = p;
`endif
            acc_q.push_back(a);
            rsp_q.push_back(r);
            seen = r.rcyc + 1;
        end
        iAddr  = ia;
        dWrite = dw;
        dAddr  = da;
        dWData = dwd;
        dWMask = dwm;
        iReq   = (mode != 1);
        dReq   = (mode != 0);
        n = 0;
        while (iReq || dReq) begin
            @(negedge clock);
            ip = iReady;
            dp = dReady;
            @(posedge clock); #1;
            if (ip) iReq = 1'b0;
            if (dp) dReq = 1'b0;
            n++;
            if (n > 60 && (iReq || dReq)) begin
                total++;
                bad++;
                $display("FAIL handshake_timeout: got no ready in %0d cycles, required completion", n);
                do_reset();
            end
        end
        @(negedge clock);
        chk("busy_idle", busy, 0);
        chk("hold_iData", iData, last_i);
        chk("hold_dRData", dRData, last_d);
        repeat ($urandom_range(0, 2)) @(posedge clock);
    endtask

    task automatic reset_mid_access(input logic [31:0] ia);
        acc_t a;
        @(posedge clock); #1;
        a.addr = ia; a.wr = 1'b0; a.wdata = '0; a.wmask = '0;
        a.scyc = cyc + 1; a.w = 5;
        acc_q.push_back(a);
        iAddr = ia;
        iReq  = 1'b1;
        @(posedge clock);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_memEnable", memEnable, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_iData", iData, 0);
        chk("rst_mid_dRData", dRData, 0);
        chk("rst_mid_access_consumed", acc_q.size(), 0);
        last_i = '0;
        last_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_m = 1'b0;
`endif
        iReq = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (8) @(negedge clock);
        chk("rst_mid_no_ready_pending", rsp_q.size(), 0);
    endtask

    initial begin
        ref_mem[32'h100] = 32'hDEADBEEF;
        bus_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h80]  = 32'hA5A5A5A5;
        bus_mem[32'h80]  = 32'hA5A5A5A5;

        #12;
        chk("rst_iReady", iReady, 0);
        chk("rst_dReady", dReady, 0);
        chk("rst_iData", iData, 0);
        chk("rst_dRData", dRData, 0);
        chk("rst_memEnable", memEnable, 0);
        chk("rst_memWrite", memWrite, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_memWData", memWData, 0);
        chk("rst_memWMask", memWMask, 0);
        chk("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        episode(0, 32'h100, 0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("single_fetch_data", iData, 32'hDEADBEEF);
        episode(1, 32'h0, 0, 1'b1, 32'h40, 32'h12345678, 32'h0000FFFF, 3);
        episode(2, 32'h200, 0, 1'b0, 32'h44, 32'h0, 32'h0, 0);
        episode(1, 32'h0, 0, 1'b0, 32'h80, 32'h0, 32'h0, 1);
        episode(0, 32'h104, 2, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("load_hold", dRData, 32'hA5A5A5A5);
        episode(1, 32'h0, 0, 1'b0, 32'h40, 32'h0, 32'h0, 0);

        reset_mid_access(32'h300);
        episode(0, 32'h100, 1, 1'b0, 32'h0, 32'h0, 32'h0, 0);

        for (int t = 0; t < 60; t++) begin
            int          m;
            logic [31:0] ia, da;
            m  = $urandom_range(0, 2);
            ia = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            da = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            episode(m, ia, $urandom_range(0, 3), 1'($urandom_range(0, 1)), da,
                    $urandom, $urandom, $urandom_range(0, 3));
        end

        repeat (4) @(negedge clock);
        chk("leftover_rsp", rsp_q.size(), 0);
        chk("leftover_acc", acc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
